video_out_fmt: RTL

Parametrised video output formatter between the VERA core's pixel outputs and a board video connector (HDMI/VGA/DVI PMOD).
- Widens or narrows colour depth per channel.
- Normalises sync polarity.
- Adds a fixed, matched pipeline delay on colour, sync and DE.
- Substitutes internal test patterns, selected through a mode register that changes only at frame boundaries.
- Replaces the fixed 12bpp direct wiring of board top levels, so one top can drive 12/18/24bpp connectors.

---
 rtl/video_out_fmt_if.sv | 39 +++
 rtl/video_out_fmt.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/video_out_fmt_if.sv
// Video formatter port bundle: core-side pixel/sync/DE and mode controls, connector-side results.
// Latency: none (wires only).
// Backpressure: none; the video stream is free-running with no flow control.
// Ports (slave view): in_r/g/b, in_hsync, in_vsync, in_de, mode_wr, mode_wdata in;
//   out_r/g/b, out_hsync, out_vsync, out_de, mode_active, mode_pending, frame_cnt out.
interface video_out_fmt_if #(
  parameter int IN_BPC  = 4,
  parameter int OUT_BPC = 4
);
  logic [IN_BPC-1:0]  in_r;
  logic [IN_BPC-1:0]  in_g;
  logic [IN_BPC-1:0]  in_b;
  logic               in_hsync;
  logic               in_vsync;
  logic               in_de;
  logic               mode_wr;
  logic [1:0]         mode_wdata;
  logic [OUT_BPC-1:0] out_r;
  logic [OUT_BPC-1:0] out_g;
  logic [OUT_BPC-1:0] out_b;
  logic               out_hsync;
  logic               out_vsync;
  logic               out_de;
  logic [1:0]         mode_active;
  logic               mode_pending;
  logic [7:0]         frame_cnt;

  modport master (
    output in_r, in_g, in_b, in_hsync, in_vsync, in_de, mode_wr, mode_wdata,
    input  out_r, out_g, out_b, out_hsync, out_vsync, out_de,
    input  mode_active, mode_pending, frame_cnt
  );

  modport slave (
    input  in_r, in_g, in_b, in_hsync, in_vsync, in_de, mode_wr, mode_wdata,
    output out_r, out_g, out_b, out_hsync, out_vsync, out_de,
    output mode_active, mode_pending, frame_cnt
  );
endinterface

// File: rtl/video_out_fmt.sv
// Video output formatter: colour depth conversion, sync polarity normalisation, test patterns.
// Latency: exactly PIPE_STAGES clk25 cycles on colour, sync and DE, all aligned.
// Backpressure: none; one pixel accepted and produced every cycle.
// Ports: clk25, reset_n (synchronous, active-low); vif (video_out_fmt_if.slave) carries
//   core pixels/sync/DE, mode write strobe/data, and connector outputs plus mode/frame status.
// Optional: define VIDEO_OUT_FMT_DITHER_EN for 2x2 ordered dither when narrowing colour depth.
module video_out_fmt #(
  parameter int IN_BPC       = 4,
  parameter int OUT_BPC      = 4,
  parameter int PIPE_STAGES  = 2,
  parameter int IN_SYNC_POL  = 0,
  parameter int OUT_SYNC_POL = 0,
  parameter int X_W          = 10,
  parameter int Y_W          = 10,
  parameter int BAR_SHIFT    = 6
) (
  input logic             clk25,
  input logic             reset_n,
  video_out_fmt_if.slave  vif
);

  localparam logic IN_POL  = (IN_SYNC_POL != 0);
  localparam logic OUT_POL = (OUT_SYNC_POL != 0);
  localparam logic [OUT_BPC-1:0] FULL = '1;

  // Internal syncs are active-high regardless of connector polarity.
  logic hs, vs;
  assign hs = vif.in_hsync ^ ~IN_POL;
  assign vs = vif.in_vsync ^ ~IN_POL;

  logic [X_W-1:0] x_cnt;
  logic [Y_W-1:0] y_cnt;
  logic           vs_q, de_q;
  logic [1:0]     mode_act, mode_pend_val;
  logic           mode_pend;
  logic [7:0]     frame_q;
  logic           vs_rise, de_fall;

  assign vs_rise = vs & ~vs_q;
  assign de_fall = de_q & ~vif.in_de;

  // MSB-aligned replication; when narrowing, the same index map reduces to keeping the MSBs.
  function automatic logic [OUT_BPC-1:0] conv(input logic [IN_BPC-1:0] v);
    logic [OUT_BPC-1:0] o;
    o = '0;
    for (int i = 0; i < OUT_BPC; i++) o[OUT_BPC-1-i] = v[IN_BPC-1-(i % IN_BPC)];
    return conv_ret(o);
  endfunction

  function automatic logic [OUT_BPC-1:0] conv_ret(input logic [OUT_BPC-1:0] o);
    return o;
  endfunction

`ifdef VIDEO_OUT_FMT_DITHER_EN
  localparam int DSH = IN_BPC - OUT_BPC;
  // Threshold sits DSH-2 bits below the kept LSB; for small DSH it is shifted right instead.
  localparam int SHL = (DSH >= 2) ? DSH - 2 : 0;
  localparam int SHR = (DSH >= 2) ? 0 : ((DSH > 0) ? 2 - DSH : 2);

  function automatic logic [IN_BPC-1:0] dither(input logic [IN_BPC-1:0] v, input logic [1:0] sel);
    logic [1:0]        t;
    logic [IN_BPC+1:0] off, sum;
    case (sel)
      2'd0:    t = 2'd0;
      2'd1:    t = 2'd2;
      2'd2:    t = 2'd3;
      default: t = 2'd1;
    endcase
    off = ((IN_BPC+2)'(t) << SHL) >> SHR;
    sum = {2'b00, v} + off;
    if (sum > {2'b00, {IN_BPC{1'b1}}}) return '1;
    return sum[IN_BPC-1:0];
  endfunction
`endif

  // Stage-0 counters and frame-boundary mode update.
  always_ff @(posedge clk25) begin
    if (!reset_n) begin
      x_cnt         <= '0;
      y_cnt         <= '0;
      vs_q          <= 1'b0;
      de_q          <= 1'b0;
      mode_act      <= 2'd0;
      mode_pend_val <= 2'd0;
      mode_pend     <= 1'b0;
      frame_q       <= 8'd0;
    end else begin
      vs_q  <= vs;
      de_q  <= vif.in_de;
      x_cnt <= vif.in_de ? x_cnt + X_W'(1) : '0;
      if (vs_rise)      y_cnt <= '0;
      else if (de_fall) y_cnt <= y_cnt + Y_W'(1);

      if (vs_rise) begin
        frame_q <= frame_q + 8'd1;
        // A write landing on the boundary itself takes effect straight away.
        if (vif.mode_wr) begin
          mode_act  <= vif.mode_wdata;
          mode_pend <= 1'b0;
        end else if (mode_pend) begin
          mode_act  <= mode_pend_val;
          mode_pend <= 1'b0;
        end
      end else if (vif.mode_wr) begin
        mode_pend_val <= vif.mode_wdata;
        mode_pend     <= 1'b1;
      end
    end
  end

  logic [IN_BPC-1:0]  src_r, src_g, src_b;
  logic [OUT_BPC-1:0] pix_r, pix_g, pix_b;
  logic [2:0]         bar;
  logic               chk;

  assign bar = x_cnt[BAR_SHIFT+2:BAR_SHIFT];
  assign chk = x_cnt[4] ^ y_cnt[4];

  always_comb begin
    src_r = vif.in_r;
    src_g = vif.in_g;
    src_b = vif.in_b;
`ifdef VIDEO_OUT_FMT_DITHER_EN
    if (DSH > 0) begin
      src_r = dither(vif.in_r, {y_cnt[0], x_cnt[0]});
      src_g = dither(vif.in_g, {y_cnt[0], x_cnt[0]});
      src_b = dither(vif.in_b, {y_cnt[0], x_cnt[0]});
    end
`endif
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    case (mode_act)
      2'd0: begin
        pix_r = conv(src_r);
        pix_g = conv(src_g);
        pix_b = conv(src_b);
      end
      2'd1: begin
        pix_r = bar[1] ? '0 : FULL;
        pix_g = bar[2] ? '0 : FULL;
        pix_b = bar[0] ? '0 : FULL;
      end
      2'd2: begin
        pix_r = chk ? FULL : '0;
        pix_g = chk ? FULL : '0;
        pix_b = chk ? FULL : '0;
      end
      default: ;
    endcase
    // Blank here: DE travels alongside, so this equals blanking on the delayed DE.
    if (!vif.in_de) begin
      pix_r = '0;
      pix_g = '0;
      pix_b = '0;
    end
  end

  logic [OUT_BPC-1:0] r_p [PIPE_STAGES];
  logic [OUT_BPC-1:0] g_p [PIPE_STAGES];
  logic [OUT_BPC-1:0] b_p [PIPE_STAGES];
  logic               hs_p [PIPE_STAGES];
  logic               vs_p [PIPE_STAGES];
  logic               de_p [PIPE_STAGES];

  always_ff @(posedge clk25) begin
    if (!reset_n) begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        r_p[i]  <= '0;
        g_p[i]  <= '0;
        b_p[i]  <= '0;
        hs_p[i] <= 1'b0;
        vs_p[i] <= 1'b0;
        de_p[i] <= 1'b0;
      end
    end else begin
      r_p[0]  <= pix_r;
      g_p[0]  <= pix_g;
      b_p[0]  <= pix_b;
      hs_p[0] <= hs;
      vs_p[0] <= vs;
      de_p[0] <= vif.in_de;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        r_p[i]  <= r_p[i-1];
        g_p[i]  <= g_p[i-1];
        b_p[i]  <= b_p[i-1];
        hs_p[i] <= hs_p[i-1];
        vs_p[i] <= vs_p[i-1];
        de_p[i] <= de_p[i-1];
      end
    end
  end

  assign vif.out_r        = r_p[PIPE_STAGES-1];
  assign vif.out_g        = g_p[PIPE_STAGES-1];
  assign vif.out_b        = b_p[PIPE_STAGES-1];
  assign vif.out_hsync    = hs_p[PIPE_STAGES-1] ^ ~OUT_POL;
  assign vif.out_vsync    = vs_p[PIPE_STAGES-1] ^ ~OUT_POL;
  assign vif.out_de       = de_p[PIPE_STAGES-1];
  assign vif.mode_active  = mode_act;
  assign vif.mode_pending = mode_pend;
  assign vif.frame_cnt    = frame_q;

endmodule
